fetch_sequencer: RTL and testbench

//  Owns the fetch PC and sequences instruction fetch over a valid/ready request and response interface to instruction memory.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_redirect_arb.sv | 35 +++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional build macro FETCH_MISALIGN_CHECK_EN is consumed by fetch_sequencer and fetch_redirect_arb.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES          = 4;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Combinational redirect arbiter: trap beats branch; target is word-aligned on output.
// With FETCH_MISALIGN_CHECK_EN defined, also flags a winning target with non-zero low bits.
module fetch_redirect_arb
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  output logic            redir_any,
  output logic [XLEN-1:0] redir_addr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            redir_misalign
`endif
);

  logic [XLEN-1:0] sel;

  always_comb begin
    // NOTE: default assignment first so every path drives sel; no latch is inferred.
    sel = branch_target;
    if (trap_req) sel = trap_target;
  end

  assign redir_any  = trap_req | branch_taken;
  assign redir_addr = sel & ~XLEN'(INSTR_BYTES - 1);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_misalign = |(sel & XLEN'(INSTR_BYTES - 1));
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: one outstanding imem request, one instruction held for decode, trap > branch redirects.
// Build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets set sticky fetch_fault and park in FAULT.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  output logic            fetch_fault
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            redir_pend;
  logic [XLEN-1:0] redir_pend_addr;
  logic            redir_any;
  logic [XLEN-1:0] redir_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            redir_misalign;
`endif

  fetch_redirect_arb #(.XLEN(XLEN)) u_arb (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap_req      (trap_req),
    .trap_target   (trap_target),
    .redir_any     (redir_any),
    .redir_addr    (redir_addr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .redir_misalign(redir_misalign)
`endif
  );

  // The request address is the PC itself; it only moves outside REQ, so it is stable until handshake.
  assign imem_req_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_BOOT;
      pc              <= RESET_VECTOR;
      imem_req_valid  <= 1'b0;
      instr_valid     <= 1'b0;
      instr_data      <= '0;
      instr_pc        <= '0;
      redir_pend      <= 1'b0;
      redir_pend_addr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later assignments in this block override earlier ones.
      unique case (state)
        ST_BOOT: begin
          imem_req_valid <= 1'b1;
          state          <= ST_REQ;
        end
        ST_REQ: begin
          if (redir_any) begin
            redir_pend      <= 1'b1;
            redir_pend_addr <= redir_addr;
          end
          if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redir_any) begin
            redir_pend      <= 1'b1;
            redir_pend_addr <= redir_addr;
          end
          if (imem_rsp_valid) begin
            if (redir_pend || redir_any) begin
              // Response belongs to a squashed path: drop it and refetch from the redirect.
              pc             <= redir_any ? redir_addr : redir_pend_addr;
              redir_pend     <= 1'b0;
              imem_req_valid <= 1'b1;
              state          <= ST_REQ;
            end else begin
              instr_data  <= imem_rsp_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redir_any) begin
            pc             <= redir_addr;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end else if (instr_ready) begin
            pc             <= pc + XLEN'(INSTR_BYTES);
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_FAULT: begin
        end
        default: state <= ST_BOOT;
      endcase

`ifdef FETCH_MISALIGN_CHECK_EN
      if (redir_any && redir_misalign &&
          (state == ST_REQ || state == ST_WAIT || state == ST_HOLD)) begin
        fetch_fault    <= 1'b1;
        imem_req_valid <= 1'b0;
        instr_valid    <= 1'b0;
        redir_pend     <= 1'b0;
        state          <= ST_FAULT;
      end
`endif
    end
  end

`ifndef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: protocol-level model checked every cycle plus directed literal checks.
// Expectations for the misaligned-branch case follow FETCH_MISALIGN_CHECK_EN when it is defined.
module tb_fetch_sequencer;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_req;
  logic [31:0] trap_target;
  logic        fetch_fault;

  fetch_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap_req      (trap_req),
    .trap_target   (trap_target),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0013_0013;
  endfunction

  // Memory timing and observation logs
  int          rsp_lat   = 1;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = '0;
  logic        nxt_valid = 1'b0;
  logic [31:0] nxt_data  = '0;
  int          cyc       = 0;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] iv_pc[$];
  int          iv_cyc[$];
  logic        prev_iv   = 1'b0;

  // Protocol model: what must be on the buses, derived from the fetch rules.
  int          m_since;
  bit          m_want, m_busy, m_kill, m_show, m_fault;
  logic [31:0] m_pc, m_kill_tgt;

  initial begin : model
    logic        redir;
    logic [31:0] tgt;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && imem_req_valid && imem_req_ready) begin
        pend_cnt  = rsp_lat;
        pend_addr = imem_req_addr;
        acc_addr.push_back(imem_req_addr);
        acc_cyc.push_back(cyc);
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        nxt_valid = (pend_cnt == 0);
      end else begin
        nxt_valid = 1'b0;
      end
      nxt_data = mem_word(pend_addr);

      if (reset) begin
        check("rst req_valid",   32'(imem_req_valid), 32'd0);
        check("rst req_addr",    imem_req_addr,       RV);
        check("rst instr_valid", 32'(instr_valid),    32'd0);
        check("rst instr_data",  instr_data,          32'd0);
        check("rst instr_pc",    instr_pc,            32'd0);
        check("rst fetch_fault", 32'(fetch_fault),    32'd0);
        m_since = 0; m_want = 0; m_busy = 0; m_kill = 0; m_show = 0; m_fault = 0;
        m_pc = RV; m_kill_tgt = '0;
      end else begin
        check("req_valid", 32'(imem_req_valid), 32'(m_want));
        if (m_want) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_show));
        if (m_show) begin
          check("instr_pc",   instr_pc,   m_pc);
          check("instr_data", instr_data, mem_word(m_pc));
        end
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (instr_valid && !prev_iv) begin
          iv_pc.push_back(instr_pc);
          iv_cyc.push_back(cyc);
        end

        redir = (m_since > 0) && !m_fault && (trap_req || branch_taken);
        tgt   = trap_req ? trap_target : branch_target;
        if (m_since == 0) begin
          m_want = 1'b1;
        end else if (redir && tgt[1:0] != 2'b00 && MISALIGN_EN) begin
          m_fault = 1'b1; m_want = 1'b0; m_show = 1'b0; m_busy = 1'b0; m_kill = 1'b0;
        end else begin
          tgt[1:0] = 2'b00;
          if (m_want) begin
            if (redir) begin m_kill = 1'b1; m_kill_tgt = tgt; end
            if (imem_req_ready) begin m_want = 1'b0; m_busy = 1'b1; end
          end else if (m_busy) begin
            if (redir) begin m_kill = 1'b1; m_kill_tgt = tgt; end
            if (imem_rsp_valid) begin
              m_busy = 1'b0;
              if (m_kill) begin m_kill = 1'b0; m_want = 1'b1; m_pc = m_kill_tgt; end
              else m_show = 1'b1;
            end
          end else if (m_show) begin
            if (redir) begin m_show = 1'b0; m_want = 1'b1; m_pc = tgt; end
            else if (instr_ready) begin m_show = 1'b0; m_want = 1'b1; m_pc = m_pc + 32'd4; end
          end
        end
        if (m_since < 2) m_since++;
      end
      prev_iv = instr_valid;
    end
  end

  // Memory response driver
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = nxt_valid;
      imem_rsp_data  = nxt_valid ? nxt_data : 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    trap_req = 1'b0;
    rsp_lat = 1;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string what);
    int k = 0;
    while (acc_addr.size() < n && k < 60) begin tick(); k++; end
    check({what, " accept seen"}, 32'(acc_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_iv(input string what);
    int k = 0;
    while (!instr_valid && k < 60) begin tick(); k++; end
    check({what, " instr_valid seen"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic redirect(input bit trap, input logic [31:0] tt, input bit br, input logic [31:0] bt);
    trap_req = trap; trap_target = tt; branch_taken = br; branch_target = bt;
    tick();
    trap_req = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a0, i0;
    reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0; trap_req = 1'b0; trap_target = '0;

    // Sequential fetch: 0x0, 0x4, 0x8 with 1-cycle memory
    a0 = acc_addr.size(); i0 = iv_pc.size();
    do_reset();
    instr_ready = 1'b1;
    repeat (12) tick();
    check("seq accepts", 32'(acc_addr.size() - a0 >= 3), 32'd1);
    check("seq req0", acc_addr[a0],     32'h0);
    check("seq req1", acc_addr[a0 + 1], 32'h4);
    check("seq req2", acc_addr[a0 + 2], 32'h8);
    check("seq pc0",  iv_pc[i0],        32'h0);
    check("seq pc2",  iv_pc[i0 + 2],    32'h8);
    check("seq latency", 32'(iv_cyc[i0] - acc_cyc[a0]), 32'd2);

    // Decode stall for 5 cycles in HOLD
    do_reset();
    instr_ready = 1'b0;
    a0 = acc_addr.size();
    wait_iv("stall");
    check("stall pc", instr_pc, 32'h0);
    repeat (5) tick();
    check("stall no new req", 32'(acc_addr.size() - a0), 32'd1);
    check("stall pc held",   instr_pc,   32'h0);
    check("stall data held", instr_data, mem_word(32'h0));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_acc(a0 + 2, "stall");
    check("stall next req", acc_addr[a0 + 1], 32'h4);

    // Branch to 0x100 while waiting on a 3-cycle response
    do_reset();
    rsp_lat = 3;
    instr_ready = 1'b1;
    a0 = acc_addr.size(); i0 = iv_pc.size();
    wait_acc(a0 + 1, "wait-branch first");
    redirect(1'b0, 32'h0, 1'b1, 32'h0000_0100);
    wait_acc(a0 + 2, "wait-branch second");
    check("wait-branch req", acc_addr[a0 + 1], 32'h100);
    check("wait-branch no old instr", 32'(iv_pc.size() - i0), 32'd0);
    wait_iv("wait-branch");
    check("wait-branch pc", instr_pc, 32'h100);

    // Trap and branch together in HOLD: trap wins
    do_reset();
    instr_ready = 1'b0;
    wait_iv("trap-vs-branch");
    redirect(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200);
    @(negedge clk);
    check("trap wins req_valid", 32'(imem_req_valid), 32'd1);
    check("trap wins addr", imem_req_addr, 32'h80);
    tick();
    wait_iv("trap-vs-branch refetch");
    check("trap wins pc", instr_pc, 32'h80);

    // Redirect in the same cycle as decode consumes
    do_reset();
    instr_ready = 1'b0;
    wait_iv("consume+redirect");
    instr_ready = 1'b1;
    redirect(1'b0, 32'h0, 1'b1, 32'h0000_0040);
    instr_ready = 1'b0;
    @(negedge clk);
    check("consume+redirect addr", imem_req_addr, 32'h40);
    check("consume+redirect req_valid", 32'(imem_req_valid), 32'd1);
    tick();

    // Misaligned branch target 0x102
    do_reset();
    instr_ready = 1'b0;
    wait_iv("misalign");
    redirect(1'b0, 32'h0, 1'b1, 32'h0000_0102);
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign fault", 32'(fetch_fault), 32'd1);
    check("misalign req_valid", 32'(imem_req_valid), 32'd0);
    repeat (4) tick();
    check("misalign parked req_valid", 32'(imem_req_valid), 32'd0);
    check("misalign parked instr_valid", 32'(instr_valid), 32'd0);
`else
    check("misalign forced addr", imem_req_addr, 32'h100);
    check("misalign no fault", 32'(fetch_fault), 32'd0);
`endif
    tick();

    // Reset mid-transaction; the stale response lands while REQ is stalled
    do_reset();
    rsp_lat = 4;
    instr_ready = 1'b1;
    a0 = acc_addr.size();
    wait_acc(a0 + 1, "late-rsp first");
    reset = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    reset = 1'b0;
    a0 = acc_addr.size();
    repeat (4) tick();
    rsp_lat = 1;
    imem_req_ready = 1'b1;
    wait_iv("late-rsp");
    check("late-rsp pc",   instr_pc,   32'h0);
    check("late-rsp data", instr_data, mem_word(32'h0));
    check("late-rsp one req", 32'(acc_addr.size() - a0), 32'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
